key_repeat_pulse_gen: RTL
=========================

// Module: key_repeat_pulse_gen
// PURPOSE
// - Front end for the clock time-set keys: turns a raw, bouncing, asynchronous push-button into the single-cycle
//   increment pulses the hours/minutes counters consume on their key inputs (one count per pulse).
// - Debounces press and release, emits one pulse per press, then auto-repeats while held (fast time setting).
// - One instance per key (hours, minutes); sits between the board pins and the counter chain.
// PARAMETERS
// - DEBOUNCE_CYCLES  1_000_000   stable-sample cycles required to accept a press or release (20 ms @ 50 MHz); >=2
// - REPEAT_DELAY     25_000_000  cycles from first pulse to first auto-repeat pulse (0.5 s); >=2
// - REPEAT_PERIOD    10_000_000  cycles between auto-repeat pulses (0.2 s); >=2
// - CNT_W            25          timer width; must hold max(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD)-1
// PORTS
// - clk        in   1  system clock; all state on rising edge
// - rst        in   1  reset, synchronous, active-high
// - en         in   1  set-mode enable; low forces FSM to IDLE, suppresses all outputs
// - key_raw    in   1  raw button, active-high, asynchronous, may bounce
// - key_pulse  out  1  one-cycle increment pulse to counter key input
// - key_level  out  1  debounced key state
// - long_press out  1  high while in auto-repeat
// BEHAVIOUR
// - Reset: sync flops, state=IDLE, timer=0, key_pulse=0, key_level=0, long_press=0; all outputs registered.
// - key_raw passes a 2-flop synchroniser (not gated by en) -> key_s; FSM uses key_s only.
// - States: IDLE, DB_PRESS, HOLD, REPEAT, DB_RELEASE. Timer cleared on every state entry.
// - IDLE: key_s=1 -> DB_PRESS.
// - DB_PRESS: key_s=0 -> IDLE. Timer==DEBOUNCE_CYCLES-1 and key_s=1 -> HOLD, key_pulse=1, key_level=1.
// - HOLD: key_s=0 -> DB_RELEASE. Timer==REPEAT_DELAY-1 -> REPEAT, key_pulse=1, long_press=1.
// - REPEAT: key_s=0 -> DB_RELEASE (long_press=0). Timer==REPEAT_PERIOD-1 -> key_pulse=1, timer=0.
// - DB_RELEASE: key_s=1 -> HOLD (repeat delay restarts, no pulse). Timer==DEBOUNCE_CYCLES-1, key_s=0 -> IDLE, key_level=0.
// - key_pulse high exactly one cycle per event; never high on consecutive cycles.
// - Latency: key_raw=1 stable from edge 1 -> first key_pulse high after edge DEBOUNCE_CYCLES+3 (2 sync + 1 entry + debounce).
// - en=0: next edge state=IDLE, timer=0, all outputs 0; key held when en rises -> fresh debounce, pulse after edge DEBOUNCE_CYCLES+1.
// - rst mid-operation (any state) overrides en and key; held key after rst release re-debounces from scratch.
// - Timer never wraps: every compare is ==limit-1 followed by clear; timer saturation is a bug.
// STRUCTURE
// - Shared include clock_ui_defs.vh: FSM state encodings (3-bit), default timing constants per clock frequency,
//   shared by the hours and minutes key instances.
// - One sub-module: sync_2ff (2-flop synchroniser, reset to 0), reused for every async board input.
// - Top: state register, single CNT_W timer, registered outputs; no combinational path key_raw -> outputs.
// TESTING (bench overrides DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3)
// - Clean tap: key_raw=1 from edge 1 for 12 cycles -> exactly one key_pulse, after edge 7; key_level 1 then 0; long_press stays 0.
// - Bounce: key_raw 1/0 alternating each cycle for 6 cycles, then stable 1 -> no pulse during bounce; one pulse 7 edges after stable start.
// - Glitch: key_raw=1 for 2 cycles only -> key_pulse, key_level, long_press all stay 0.
// - Hold 40 cycles -> pulses after edges 7, 17, 20, 23, 26, ... until release; long_press high from edge 17; no pulse after release.
// - Release dropout: in HOLD, key_raw low for 2 cycles -> no pulse, no key_level drop, repeat delay restarts (next pulse 10 edges after return to HOLD).
// - rst pulse in REPEAT with key held -> outputs 0 on next edge; next pulse after edge 7 counted from rst deassertion.
// - en=0 during hold -> no pulses, outputs 0; en=1 with key held -> pulse after edge 5 counted from en rise.

Source files
------------

// File: rtl/key_repeat_pulse_gen_pkg.sv
// Shared definitions for the clock time-set key front end. The hours and
// minutes key instances both use these definitions.
//   - FSM state encodings (3-bit)
//   - default timing constants for a 50 MHz system clock
//   - registered output bundle type
package key_repeat_pulse_gen_pkg;

  // FSM state encodings
  localparam logic [2:0] ST_IDLE       = 3'd0;
  localparam logic [2:0] ST_DB_PRESS   = 3'd1;
  localparam logic [2:0] ST_HOLD       = 3'd2;
  localparam logic [2:0] ST_REPEAT     = 3'd3;
  localparam logic [2:0] ST_DB_RELEASE = 3'd4;

  // Default timing at 50 MHz: 20 ms debounce, 0.5 s first repeat, 0.2 s repeat
  localparam int DEF_DEBOUNCE_CYCLES = 1_000_000;
  localparam int DEF_REPEAT_DELAY    = 25_000_000;
  localparam int DEF_REPEAT_PERIOD   = 10_000_000;
  localparam int DEF_CNT_W           = 25;

  // Registered outputs, kept together so reset and en-gating clear them as one
  typedef struct packed {
    logic pulse;
    logic level;
    logic long_press;
  } key_out_t;

  localparam key_out_t KEY_OUT_IDLE = '{pulse: 1'b0, level: 1'b0, long_press: 1'b0};

endpackage

// File: rtl/key_repeat_pulse_gen_if.sv
// Key front-end signal bundle.
//   en         : set-mode enable (low forces idle, outputs low)
//   key_raw    : raw asynchronous push-button, active-high, may bounce
//   key_pulse  : one-cycle increment pulse to the counter key input
//   key_level  : debounced key state
//   long_press : high while auto-repeating
// master = board/controller side, slave = key_repeat_pulse_gen.
interface key_repeat_pulse_gen_if;
  logic en;
  logic key_raw;
  logic key_pulse;
  logic key_level;
  logic long_press;

  modport master (
    output en, key_raw,
    input  key_pulse, key_level, long_press
  );

  modport slave (
    input  en, key_raw,
    output key_pulse, key_level, long_press
  );
endinterface

// File: rtl/key_repeat_pulse_gen_sync_2ff.sv
// sync_2ff: two-flop synchroniser for asynchronous board inputs.
//   clk : system clock
//   rst : synchronous active-high reset, both flops clear to 0
//   d_i : asynchronous input
//   q_o : synchronised output, two cycles of latency
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);
  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;
endmodule

// File: rtl/key_repeat_pulse_gen.sv
// key_repeat_pulse_gen: converts a raw, bouncing push-button into single-cycle
// increment pulses. It debounces press and release, emits one pulse per
// press, and auto-repeats while the key is held.
//   clk : system clock, rising edge
//   rst : synchronous active-high reset
//   kif : key_repeat_pulse_gen_if.slave
//         (en, key_raw in; key_pulse, key_level, long_press out)
// All outputs are registered. There is no combinational path from key_raw to
// any output.
module key_repeat_pulse_gen
  import key_repeat_pulse_gen_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
  parameter int CNT_W           = DEF_CNT_W
) (
  input  logic            clk,
  input  logic            rst,
  key_repeat_pulse_gen_if.slave kif
);

  localparam logic [CNT_W-1:0] DB_LIM  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DLY_LIM = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] PER_LIM = CNT_W'(REPEAT_PERIOD - 1);

  logic             key_s;
  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  key_out_t         out_q, out_d;

  // The synchroniser is not gated by en. This keeps key_s valid the moment
  // en rises, so a held key debounces without first waiting out the sync delay.
  sync_2ff u_sync (
    .clk (clk),
    .rst (rst),
    .d_i (kif.key_raw),
    .q_o (key_s)
  );

  always_comb begin
    state_d              = state_q;
    timer_d              = timer_q + 1'b1;
    out_d                = out_q;
    out_d.pulse          = 1'b0;

    // Every transition clears the timer. Each limit compare is followed by a
    // clear or a state change, so the timer cannot run past its limit.
    unique case (state_q)
      ST_IDLE: begin
        timer_d          = '0;
        out_d.level      = 1'b0;
        out_d.long_press = 1'b0;
        if (key_s) state_d = ST_DB_PRESS;
      end
      ST_DB_PRESS: begin
        if (!key_s) begin
          state_d = ST_IDLE;
          timer_d = '0;
        end else if (timer_q == DB_LIM) begin
          state_d     = ST_HOLD;
          timer_d     = '0;
          out_d.pulse = 1'b1;
          out_d.level = 1'b1;
        end
      end
      ST_HOLD: begin
        if (!key_s) begin
          state_d = ST_DB_RELEASE;
          timer_d = '0;
        end else if (timer_q == DLY_LIM) begin
          state_d          = ST_REPEAT;
          timer_d          = '0;
          out_d.pulse      = 1'b1;
          out_d.long_press = 1'b1;
        end
      end
      ST_REPEAT: begin
        if (!key_s) begin
          state_d          = ST_DB_RELEASE;
          timer_d          = '0;
          out_d.long_press = 1'b0;
        end else if (timer_q == PER_LIM) begin
          timer_d     = '0;
          out_d.pulse = 1'b1;
        end
      end
      ST_DB_RELEASE: begin
        // A bounce back to pressed counts as still held. The repeat delay
        // restarts and no pulse is emitted.
        if (key_s) begin
          state_d = ST_HOLD;
          timer_d = '0;
        end else if (timer_q == DB_LIM) begin
          state_d     = ST_IDLE;
          timer_d     = '0;
          out_d.level = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        timer_d = '0;
        out_d   = KEY_OUT_IDLE;
      end
    endcase

    // Leaving set mode drops everything. A key still held when en returns
    // must debounce again from the beginning.
    if (!kif.en) begin
      state_d = ST_IDLE;
      timer_d = '0;
      out_d   = KEY_OUT_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      timer_q <= '0;
      out_q   <= KEY_OUT_IDLE;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      out_q   <= out_d;
    end
  end

  assign kif.key_pulse  = out_q.pulse;
  assign kif.key_level  = out_q.level;
  assign kif.long_press = out_q.long_press;

endmodule
